instruction_fetch: RTL and testbench

- Front end of the 8-bit CPU. Drives the address, write-enable and write-data inputs of the 256x8 program/data memory, and captures its combinational read data.
- Sequences a program counter (PC) and assembles 1- or 2-byte instructions for decode using a valid/ready handshake.
- Shares the single memory port with load/store accesses from execute. The data side has priority on every cycle.

---
 rtl/instruction_fetch.sv | 180 ++++++++++++++++++
 tb/tb_instruction_fetch.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Front end of the 8-bit CPU. Owns the single port of the 256x8 program/data
// memory, sequences the program counter and assembles 1- or 2-byte
// instructions for decode over a valid/ready handshake. Load/store accesses
// from execute take the memory port whenever dataReq is high; instruction
// fetch stalls in those cycles.
//
// Ports:
//   clock, resetN                  clock, asynchronous active-low reset
//   memAddress/WriteEnable/        memory port (address, write strobe,
//   memWriteData, memData          write data, combinational read data)
//   dataReq/Write/Address/         load/store request from execute
//   dataWriteData
//   dataReadData, dataAck          load result, access performed this cycle
//   branchTaken, branchTarget      PC redirect (highest priority)
//   instrValid/Ready/Opcode/       instruction handshake towards decode
//   instrOperand/Pc
//
// Parameters:
//   RESET_PC     PC value loaded on reset
//   LONG_OP_BIT  opcode bit marking a 2-byte instruction
//
// Build option:
//   FETCH_BYPASS_EN  when defined, an accepted instruction in ISSUE fetches
//                    the next opcode in the same cycle (1 instr/cycle for
//                    back-to-back 1-byte ops).
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter int         LONG_OP_BIT = 7
) (
  input  logic       clock,
  input  logic       resetN,
  output logic [7:0] memAddress,
  output logic       memWriteEnable,
  output logic [7:0] memWriteData,
  input  logic [7:0] memData,
  input  logic       dataReq,
  input  logic       dataWrite,
  input  logic [7:0] dataAddress,
  input  logic [7:0] dataWriteData,
  output logic [7:0] dataReadData,
  output logic       dataAck,
  input  logic       branchTaken,
  input  logic [7:0] branchTarget,
  output logic       instrValid,
  input  logic       instrReady,
  output logic [7:0] instrOpcode,
  output logic [7:0] instrOperand,
  output logic [7:0] instrPc
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    ISSUE     = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic [7:0] instr_pc_q, instr_pc_d;

  logic long_op;       // byte on memData is an opcode with an operand
  logic bypass_fetch;  // ISSUE hands off and fetches the next opcode at once
  logic fetch_op;      // opcode byte captured this cycle
  logic fetch_arg;     // operand byte captured this cycle

  assign long_op = memData[LONG_OP_BIT];

`ifdef FETCH_BYPASS_EN
  // memAddress is already pc whenever dataReq is low, so the opcode is on
  // memData in the accepting cycle.
  assign bypass_fetch = (state_q == ISSUE) && instrReady && !dataReq && !branchTaken;
`else
  assign bypass_fetch = 1'b0;
`endif

  assign fetch_op  = !branchTaken &&
                     (((state_q == FETCH_OP) && !dataReq) || bypass_fetch);
  assign fetch_arg = !branchTaken && (state_q == FETCH_ARG) && !dataReq;

  // Memory port mux: the data side owns the port whenever it asks for it.
  // NOTE: every signal gets a default at the top of an always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    memAddress     = pc_q;
    memWriteEnable = 1'b0;
    memWriteData   = 8'h00;
    dataAck        = 1'b0;
    if (dataReq) begin
      memAddress     = dataAddress;
      // Gated by resetN so a store can never hit memory while in reset.
      memWriteEnable = dataWrite & resetN;
      memWriteData   = dataWriteData;
      dataAck        = 1'b1;
    end
  end

  assign dataReadData = memData;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= FETCH_OP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A branch wins over everything; a dataReq stalls the
  // fetch states but never blocks acceptance in ISSUE.
  always_comb begin
    state_d = state_q;
    if (branchTaken) begin
      state_d = FETCH_OP;
    end else begin
      case (state_q)
        FETCH_OP:  if (!dataReq) state_d = long_op ? FETCH_ARG : ISSUE;
        FETCH_ARG: if (!dataReq) state_d = ISSUE;
        ISSUE: begin
          if (instrReady) begin
            if (bypass_fetch) state_d = long_op ? FETCH_ARG : ISSUE;
            else              state_d = FETCH_OP;
          end
        end
        default:   state_d = FETCH_OP;
      endcase
    end
  end

  // Outputs from state.
  always_comb begin
    instrValid = (state_q == ISSUE);
  end

  // Datapath: pc and the instruction holding registers. They only change on
  // a fetch, so they stay stable in ISSUE while decode is not ready.
  always_comb begin
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    instr_pc_d = instr_pc_q;
    if (branchTaken) begin
      pc_d = branchTarget;
    end else if (fetch_op) begin
      opcode_d   = memData;
      instr_pc_d = pc_q;
      pc_d       = pc_q + 8'd1;
      if (!long_op) operand_d = 8'h00;
    end else if (fetch_arg) begin
      operand_d = memData;
      pc_d      = pc_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pc_q       <= RESET_PC;
      opcode_q   <= 8'h00;
      operand_q  <= 8'h00;
      instr_pc_q <= 8'h00;
    end else begin
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign instrOpcode  = opcode_q;
  assign instrOperand = operand_q;
  assign instrPc      = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Self-checking bench for instruction_fetch. Holds a 256x8 memory with
// combinational read, a shadow copy of its expected contents, and an
// instruction-stream model: the next instruction to issue is always
// {mem[pc], long ? mem[pc+1] : 0, pc}, and pc advances by the instruction
// length on a handshake or jumps on a branch.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  logic       clock = 1'b0;
  logic       resetN;
  logic [7:0] memAddress;
  logic       memWriteEnable;
  logic [7:0] memWriteData;
  logic [7:0] memData;
  logic       dataReq;
  logic       dataWrite;
  logic [7:0] dataAddress;
  logic [7:0] dataWriteData;
  logic [7:0] dataReadData;
  logic       dataAck;
  logic       branchTaken;
  logic [7:0] branchTarget;
  logic       instrValid;
  logic       instrReady;
  logic [7:0] instrOpcode;
  logic [7:0] instrOperand;
  logic [7:0] instrPc;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_BYPASS_EN
  localparam int SEQ_GAP = 1;
`else
  localparam int SEQ_GAP = 2;
`endif

  instruction_fetch dut (
    .clock         (clock),
    .resetN        (resetN),
    .memAddress    (memAddress),
    .memWriteEnable(memWriteEnable),
    .memWriteData  (memWriteData),
    .memData       (memData),
    .dataReq       (dataReq),
    .dataWrite     (dataWrite),
    .dataAddress   (dataAddress),
    .dataWriteData (dataWriteData),
    .dataReadData  (dataReadData),
    .dataAck       (dataAck),
    .branchTaken   (branchTaken),
    .branchTarget  (branchTarget),
    .instrValid    (instrValid),
    .instrReady    (instrReady),
    .instrOpcode   (instrOpcode),
    .instrOperand  (instrOperand),
    .instrPc       (instrPc)
  );

  always #5 clock = ~clock;

  // Memory plus a bench-side preload path.
  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = 8'h00;
  logic [7:0] pl_data = 8'h00;

  assign memData = mem[memAddress];

  always @(posedge clock) begin
    if (memWriteEnable)  mem[memAddress] <= memWriteData;
    else if (pl_en)      mem[pl_addr]    <= pl_data;
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    exp_mem[a] = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!instrValid && lat < 20) begin
      step();
      lat++;
    end
    if (!instrValid) begin
      errors++;
      $display("FAIL wait_valid: instrValid still %b after %0d cycles", instrValid, lat);
    end
    checks++;
  endtask

  task automatic test_reset();
    resetN = 1'b0; dataReq = 1'b0; dataWrite = 1'b0; dataAddress = 8'h00;
    dataWriteData = 8'h00; branchTaken = 1'b0; branchTarget = 8'h00; instrReady = 1'b0;
    step();
    for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom_range(0, 255)));
    poke(8'h00, 8'h01);
    poke(8'h01, 8'h02);
    poke(8'h02, 8'h00);
    // A store attempt while in reset must not reach memory.
    dataReq = 1'b1; dataWrite = 1'b1; dataAddress = 8'h33; dataWriteData = 8'h5A;
    #1;
    if (memWriteEnable !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", memWriteEnable); end
    checks++;
    if (memAddress !== 8'h33) begin errors++; $display("FAIL rst_dmux: got %h expected 33", memAddress); end
    checks++;
    dataReq = 1'b0; dataWrite = 1'b0;
    #1;
    if (instrValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instrValid); end
    checks++;
    if ({instrOpcode, instrOperand, instrPc} !== 24'h0) begin
      errors++; $display("FAIL rst_regs: got %h expected 000000", {instrOpcode, instrOperand, instrPc});
    end
    checks++;
    if (memAddress !== 8'h00) begin errors++; $display("FAIL rst_pc: got %h expected 00", memAddress); end
    checks++;
  endtask

  task automatic test_sequential();
    int         cyc [2] = '{-1, -1};
    logic [7:0] op  [2] = '{8'hXX, 8'hXX};
    logic [7:0] pcv [2] = '{8'hXX, 8'hXX};
    int         n = 0;
    instrReady = 1'b1;
    resetN = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (instrValid && n < 2) begin
        cyc[n] = c; op[n] = instrOpcode; pcv[n] = instrPc; n++;
      end
    end
    instrReady = 1'b0;
    if (cyc[0] !== 1) begin errors++; $display("FAIL seq_latency: got %0d expected 1", cyc[0]); end
    checks++;
    if (op[0] !== 8'h01 || pcv[0] !== 8'h00) begin
      errors++; $display("FAIL seq_first: got op %h pc %h expected op 01 pc 00", op[0], pcv[0]);
    end
    checks++;
    if (op[1] !== 8'h02 || pcv[1] !== 8'h01) begin
      errors++; $display("FAIL seq_second: got op %h pc %h expected op 02 pc 01", op[1], pcv[1]);
    end
    checks++;
    if (cyc[1] - cyc[0] !== SEQ_GAP) begin
      errors++; $display("FAIL seq_gap: got %0d expected %0d", cyc[1] - cyc[0], SEQ_GAP);
    end
    checks++;
  endtask

  task automatic test_long_branch();
    int lat;
    poke(8'h04, 8'h85);
    poke(8'h05, 8'h3C);
    poke(8'h06, 8'h00);
    instrReady = 1'b0;
    branchTaken = 1'b1; branchTarget = 8'h04;
    step();
    branchTaken = 1'b0;
    #1;
    if (instrValid !== 1'b0) begin errors++; $display("FAIL br_valid_drop: got %b expected 0", instrValid); end
    checks++;
    wait_valid(lat);
    if (lat !== 2) begin errors++; $display("FAIL long_latency: got %0d expected 2", lat); end
    checks++;
    if ({instrOpcode, instrOperand, instrPc} !== 24'h853C04) begin
      errors++; $display("FAIL long_instr: got %h expected 853c04", {instrOpcode, instrOperand, instrPc});
    end
    checks++;
    instrReady = 1'b1;
    #1;
    if (memAddress !== 8'h06) begin errors++; $display("FAIL long_next_pc: got %h expected 06", memAddress); end
    checks++;
    step();
    instrReady = 1'b0;
  endtask

  task automatic test_wrap();
    int lat;
    poke(8'hFF, 8'h90);
    poke(8'h00, 8'h07);
    poke(8'h01, 8'h00);
    branchTaken = 1'b1; branchTarget = 8'hFF;
    step();
    branchTaken = 1'b0;
    wait_valid(lat);
    if ({instrOpcode, instrOperand, instrPc} !== 24'h9007FF) begin
      errors++; $display("FAIL wrap_instr: got %h expected 9007ff", {instrOpcode, instrOperand, instrPc});
    end
    checks++;
    if (memAddress !== 8'h01) begin errors++; $display("FAIL wrap_pc: got %h expected 01", memAddress); end
    checks++;
  endtask

  task automatic test_store_stall();
    poke(8'h20, 8'h9A);
    poke(8'h21, 8'h55);
    poke(8'h22, 8'h00);
    poke(8'h80, 8'h11);
    poke(8'h10, 8'h03);
    poke(8'h11, 8'h00);
    instrReady = 1'b0;
    branchTaken = 1'b1; branchTarget = 8'h20;
    step();
    branchTaken = 1'b0;
    step();
    if (instrValid !== 1'b0 || memAddress !== 8'h21) begin
      errors++; $display("FAIL arg_state: got valid %b addr %h expected valid 0 addr 21", instrValid, memAddress);
    end
    checks++;
    dataReq = 1'b1; dataWrite = 1'b1; dataAddress = 8'h80; dataWriteData = 8'hAA;
    #1;
    if ({memWriteEnable, dataAck, memAddress, memWriteData} !== {1'b1, 1'b1, 8'h80, 8'hAA}) begin
      errors++; $display("FAIL store_port: got we %b ack %b addr %h wd %h expected 1 1 80 aa",
                         memWriteEnable, dataAck, memAddress, memWriteData);
    end
    checks++;
    step();
    dataReq = 1'b0; dataWrite = 1'b0;
    #1;
    if (instrValid !== 1'b0 || memAddress !== 8'h21) begin
      errors++; $display("FAIL store_stall: got valid %b addr %h expected valid 0 addr 21", instrValid, memAddress);
    end
    checks++;
    step();
    if (instrValid !== 1'b1 || {instrOpcode, instrOperand, instrPc} !== 24'h9A5520) begin
      errors++; $display("FAIL stall_instr: got valid %b %h expected valid 1 9a5520",
                         instrValid, {instrOpcode, instrOperand, instrPc});
    end
    checks++;
    dataReq = 1'b1; dataWrite = 1'b0; dataAddress = 8'h80;
    #1;
    if (dataReadData !== 8'hAA || memWriteEnable !== 1'b0 || dataAck !== 1'b1) begin
      errors++; $display("FAIL load_80: got data %h we %b ack %b expected aa 0 1",
                         dataReadData, memWriteEnable, dataAck);
    end
    checks++;
    dataReq = 1'b0;
  endtask

  task automatic test_hold_branch();
    int lat;
    for (int i = 1; i <= 3; i++) begin
      branchTaken = (i == 3); branchTarget = 8'h10;
      #1;
      if (instrValid !== 1'b1 || {instrOpcode, instrOperand, instrPc} !== 24'h9A5520 || memAddress !== 8'h22) begin
        errors++; $display("FAIL hold_%0d: got valid %b %h addr %h expected valid 1 9a5520 addr 22",
                           i, instrValid, {instrOpcode, instrOperand, instrPc}, memAddress);
      end
      checks++;
      step();
    end
    branchTaken = 1'b0;
    #1;
    if (instrValid !== 1'b0 || memAddress !== 8'h10) begin
      errors++; $display("FAIL hold_branch: got valid %b addr %h expected valid 0 addr 10", instrValid, memAddress);
    end
    checks++;
    wait_valid(lat);
    if (instrOpcode !== 8'h03 || instrPc !== 8'h10 || lat !== 1) begin
      errors++; $display("FAIL branch_instr: got op %h pc %h lat %0d expected op 03 pc 10 lat 1",
                         instrOpcode, instrPc, lat);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    int lat;
    poke(8'h00, 8'h05);
    instrReady = 1'b0;
    branchTaken = 1'b1; branchTarget = 8'h20;
    step();
    branchTaken = 1'b0;
    step();
    if (instrOpcode !== 8'h9A) begin errors++; $display("FAIL mid_pre: got %h expected 9a", instrOpcode); end
    checks++;
    resetN = 1'b0;
    #1;
    if ({instrValid, instrOpcode, instrOperand, instrPc, memAddress} !== 33'h0) begin
      errors++; $display("FAIL mid_reset: got valid %b %h addr %h expected all zero",
                         instrValid, {instrOpcode, instrOperand, instrPc}, memAddress);
    end
    checks++;
    dataReq = 1'b1; dataWrite = 1'b1; dataAddress = 8'h44; dataWriteData = 8'hEE;
    #1;
    if (memWriteEnable !== 1'b0) begin errors++; $display("FAIL mid_we: got %b expected 0", memWriteEnable); end
    checks++;
    dataReq = 1'b0; dataWrite = 1'b0;
    step();
    resetN = 1'b1;
    instrReady = 1'b1;
    wait_valid(lat);
    if ({instrOpcode, instrOperand, instrPc} !== 24'h050000 || lat !== 1) begin
      errors++; $display("FAIL mid_restart: got %h lat %0d expected 050000 lat 1",
                         {instrOpcode, instrOperand, instrPc}, lat);
    end
    checks++;
    instrReady = 1'b0;
  endtask

  // Random load/store, branch and handshake traffic. Code and branch targets
  // stay below 8'hC0 and stores go to 8'hF0..8'hFF so code is never rewritten.
  task automatic test_random();
    int         accepted = 0;
    int         idle = 0;
    bit         prev_br = 1'b0;
    bit         dreq, dwr, br, rdy;
    logic [7:0] exp_pc, op, arg, tgt, da, wd;
    resetN = 1'b0; instrReady = 1'b0; dataReq = 1'b0; branchTaken = 1'b0;
    for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom_range(0, 255)));
    resetN = 1'b1;
    exp_pc = 8'h00;
    for (int c = 0; c < 2000; c++) begin
      dreq = ($urandom_range(0, 3) == 0);
      dwr  = 1'($urandom_range(0, 1));
      da   = dwr ? (8'hF0 | 8'($urandom_range(0, 15))) : 8'($urandom_range(0, 255));
      wd   = 8'($urandom_range(0, 255));
      br   = ($urandom_range(0, 9) == 0) || (exp_pc >= 8'hC0);
      tgt  = 8'($urandom_range(0, 191));
      rdy  = ($urandom_range(0, 2) != 0);
      dataReq = dreq; dataWrite = dwr; dataAddress = da; dataWriteData = wd;
      branchTaken = br; branchTarget = tgt; instrReady = rdy;
      #1;
      if (dreq) begin
        if ({dataAck, memWriteEnable, memAddress, memWriteData} !== {1'b1, dwr, da, wd}) begin
          errors++; $display("FAIL rnd_port c%0d: got ack %b we %b addr %h wd %h expected 1 %b %h %h",
                             c, dataAck, memWriteEnable, memAddress, memWriteData, dwr, da, wd);
        end
        checks++;
        if (!dwr) begin
          if (dataReadData !== exp_mem[da]) begin
            errors++; $display("FAIL rnd_load c%0d: got %h expected %h", c, dataReadData, exp_mem[da]);
          end
          checks++;
        end
      end else begin
        if ({dataAck, memWriteEnable, memWriteData} !== 10'h0) begin
          errors++; $display("FAIL rnd_idle_port c%0d: got ack %b we %b wd %h expected 0 0 00",
                             c, dataAck, memWriteEnable, memWriteData);
        end
        checks++;
      end
      if (prev_br) begin
        if (instrValid !== 1'b0) begin errors++; $display("FAIL rnd_br_drop c%0d: got %b expected 0", c, instrValid); end
        checks++;
      end
      op = exp_mem[exp_pc];
      if (instrValid) begin
        arg = op[7] ? exp_mem[exp_pc + 8'd1] : 8'h00;
        if ({instrOpcode, instrOperand, instrPc} !== {op, arg, exp_pc}) begin
          errors++; $display("FAIL rnd_instr c%0d: got %h expected %h", c,
                             {instrOpcode, instrOperand, instrPc}, {op, arg, exp_pc});
        end
        checks++;
      end
      if (instrValid || br) idle = 0;
      else idle++;
      if (idle > 40) begin
        errors++; checks++; idle = 0;
        $display("FAIL rnd_progress c%0d: got no instruction for 41 cycles expected one", c);
      end
      if (dreq && dwr) exp_mem[da] = wd;
      if (instrValid && rdy) begin
        accepted++;
        exp_pc = exp_pc + (op[7] ? 8'd2 : 8'd1);
      end
      if (br) exp_pc = tgt;
      prev_br = br;
      step();
    end
    dataReq = 1'b0; dataWrite = 1'b0; branchTaken = 1'b0; instrReady = 1'b0;
    if (accepted < 100) begin errors++; $display("FAIL rnd_accepted: got %0d expected >= 100", accepted); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_long_branch();
    test_wrap();
    test_store_stall();
    test_hold_branch();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
